// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the clock divider scheduler.
// Holds the FSM state encoding, quiesce length and N legality check.
package clkdiv_pkg;

  typedef enum logic [2:0] {
    BOOT,
    IDLE,
    WAIT_LOW,
    QUIESCE,
    LOAD,
    SETTLE,
    DONE
  } state_t;

  localparam int QUIESCE_CYCLES = 2;
  localparam int MAX_W = 64;

  // An even divider can only take nonzero even factors.
  function automatic logic is_legal_n(
    input logic [MAX_W-1:0] n
  );
    return (n != '0) && !n[0];
  endfunction

endpackage

// File: rtl/clkdiv_sched_rr_arbiter.sv
// Combinational round-robin arbiter; search starts at ptr.
// Ports: req, ptr in; gnt (one-hot), idx, valid out.
module rr_arbiter #(
  parameter int NREQ = 2,
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            valid
);

  logic [PW:0]   s;
  logic [PW-1:0] j;

  // Walk offsets from far to near so the nearest
  // requester after ptr is the one left standing.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    s     = '0;
    j     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      s = {1'b0, ptr} + (PW+1)'(k);
      if (s >= (PW+1)'(NREQ))
        s = s - (PW+1)'(NREQ);
      j = s[PW-1:0];
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = j;
        valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/clkdiv_sched.sv
// Shares one even divider among NREQ requesters with glitch-free
// reconfiguration: wait div_out low, disable, load N, enable, settle, ack.
// Ports: clk, reset_n (sync, active-low); req/req_n from requesters;
//        ack/err one-hot pulses; div_out in; div_n/div_en to divider;
//        cur_n active factor; busy while reconfiguring.
module clkdiv_sched #(
  parameter int WIDTH     = 32,
  parameter int NREQ      = 2,
  parameter int DEFAULT_N = 2,
  parameter int SETTLE    = 4,
  parameter int TIMEOUT   = 1024
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_n,
  output logic [NREQ-1:0]       ack,
  output logic [NREQ-1:0]       err,
  input  logic                  div_out,
  output logic [WIDTH-1:0]      div_n,
  output logic                  div_en,
  output logic [WIDTH-1:0]      cur_n,
  output logic                  busy
);

  import clkdiv_pkg::*;

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(SETTLE + QUIESCE_CYCLES + 1);
  localparam logic [WIDTH-1:0] DN = WIDTH'(DEFAULT_N);

  state_t           state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gidx;
  logic [PW-1:0]    ptr_nx;
  logic [PW:0]      inc;
  logic [NREQ-1:0]  gnt;
  logic [NREQ-1:0]  gsel;
  logic             gvalid;
  logic [WIDTH-1:0] nreq;
  logic [WIDTH-1:0] gn;
  logic [WIDTH-1:0] rn [NREQ];
  logic [TW-1:0]    wcnt;
  logic [CW-1:0]    cnt;

  for (genvar i = 0; i < NREQ; i++) begin : g_rn
    assign rn[i] = req_n[i*WIDTH +: WIDTH];
  end

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req   (req),
    .ptr   (ptr),
    .gnt   (gnt),
    .idx   (gidx),
    .valid (gvalid)
  );

  assign gn     = rn[gidx];
  assign inc    = {1'b0, gidx} + (PW+1)'(1);
  assign ptr_nx = (inc == (PW+1)'(NREQ)) ? '0
                                         : inc[PW-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= BOOT;
      div_en <= 1'b0;
      div_n  <= DN;
      cur_n  <= DN;
      nreq   <= DN;
      ack    <= '0;
      err    <= '0;
      busy   <= 1'b0;
      ptr    <= '0;
      gsel   <= '0;
      wcnt   <= '0;
      cnt    <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      unique case (state)
        BOOT: begin
          div_en <= 1'b1;
          state  <= IDLE;
        end
        IDLE: begin
          // Hold off one cycle after an immediate ack so
          // the requester can drop req before re-arbitration.
          if (gvalid && ack == '0) begin
            ptr  <= ptr_nx;
            nreq <= gn;
            gsel <= gnt;
            if (!is_legal_n(MAX_W'(gn))) begin
              ack <= gnt;
              err <= gnt;
            end else if (gn == cur_n) begin
              ack <= gnt;
            end else begin
              busy  <= 1'b1;
              wcnt  <= '0;
              state <= WAIT_LOW;
            end
          end
        end
        WAIT_LOW: begin
          if (!div_out || wcnt == TW'(TIMEOUT - 1)) begin
            div_en <= 1'b0;
            cnt    <= '0;
            state  <= QUIESCE;
          end else begin
            wcnt <= wcnt + TW'(1);
          end
        end
        QUIESCE: begin
          if (cnt == CW'(QUIESCE_CYCLES - 1)) begin
            cnt   <= '0;
            state <= LOAD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LOAD: begin
          div_n  <= nreq;
          cur_n  <= nreq;
          div_en <= 1'b1;
          cnt    <= '0;
          state  <= clkdiv_pkg::SETTLE;
        end
        clkdiv_pkg::SETTLE: begin
          if (cnt == CW'(SETTLE - 1)) begin
            ack   <= gsel;
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_clkdiv_sched.sv
// Randomized bench for clkdiv_sched against a transaction-level model.
// Model predicts grant order, err, ack edge, and active N.
module tb_clkdiv_sched;

  localparam int W  = 32;
  localparam int NR = 2;
  localparam int ST = 4;
  localparam int TO = 12;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] req_n;
  logic [NR-1:0]   ack;
  logic [NR-1:0]   err;
  logic            div_out;
  logic [W-1:0]    div_n;
  logic            div_en;
  logic [W-1:0]    cur_n;
  logic            busy;

  clkdiv_sched #(
    .WIDTH     (W),
    .NREQ      (NR),
    .DEFAULT_N (2),
    .SETTLE    (ST),
    .TIMEOUT   (TO)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .req_n   (req_n),
    .ack     (ack),
    .err     (err),
    .div_out (div_out),
    .div_n   (div_n),
    .div_en  (div_en),
    .cur_n   (cur_n),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Edge counter and div_out history as seen at each edge.
  int ecnt = 0;
  bit dh [int];
  bit rq = 1'b0;
  always @(posedge clk) begin
    ecnt++;
    dh[ecnt] = div_out;
    rq = reset_n;
  end

  // Divider-side rules: div_n frozen while enabled,
  // and exactly 3 disabled cycles per reconfiguration.
  logic         pen = 1'b0;
  logic [W-1:0] pdn = '0;
  bit           armed = 1'b0;
  int           lowc = 0;
  always @(negedge clk) begin
    if (!rq) begin
      armed = 1'b0;
    end else begin
      if (div_n !== pdn)
        check("dn_while_en", pen, 0);
      if (pen && !div_en) begin
        armed = 1'b1;
        lowc  = 1;
      end else if (!div_en && armed) begin
        lowc++;
      end else if (div_en && !pen && armed) begin
        check("en_low_cycles", lowc, 3);
        armed = 1'b0;
      end
    end
    pen = div_en;
    pdn = div_n;
  end

  int dmode = 0;

  task automatic step();
    @(negedge clk);
    case (dmode)
      0:       div_out = 1'b0;
      1:       div_out = 1'b1;
      default: div_out = ($urandom_range(3) != 0);
    endcase
  endtask

  int           ptr_m = 0;
  logic [W-1:0] cur_m = 2;

  function automatic logic [W-1:0] pick();
    case ($urandom_range(3))
      0:       return '0;
      1:       return W'(2 * $urandom_range(1, 10) + 1);
      2:       return cur_m;
      default: return W'(2 * $urandom_range(1, 10));
    endcase
  endfunction

  task automatic chk_rst();
    check("rst_en",   div_en, 0);
    check("rst_divn", div_n,  2);
    check("rst_curn", cur_n,  2);
    check("rst_ack",  ack,    0);
    check("rst_err",  err,    0);
    check("rst_busy", busy,   0);
  endtask

  task automatic batch(
    input logic [NR-1:0] m,
    input logic [W-1:0]  n0,
    input logic [W-1:0]  n1
  );
    logic [W-1:0]  nv [NR];
    logic [NR-1:0] pend;
    int            e0, g, d, exp_e, waited;
    bit            ok, reconf;
    nv[0] = n0;
    nv[1] = n1;
    req_n = {n1, n0};
    req   = m;
    pend  = m;
    e0    = ecnt + 1;
    while (pend != 0) begin
      waited = 0;
      while (ack == 0 && waited < 300) begin
        step();
        waited++;
      end
      if (ack == 0) begin
        check("ack_timeout", 0, 1);
        break;
      end
      g = ptr_m;
      while (!pend[g]) g = (g + 1) % NR;
      ok     = (nv[g] != 0) && (nv[g] % 2 == 0);
      reconf = ok && (nv[g] != cur_m);
      exp_e  = e0;
      if (reconf) begin
        d = TO;
        for (int k = 1; k <= TO; k++) begin
          if (!dh[e0 + k]) begin
            d = k;
            break;
          end
        end
        exp_e = e0 + d + 3 + ST;
      end
      check("ack_who",  ack, 64'(1) << g);
      check("err",      err, ok ? 64'(0) : (64'(1) << g));
      check("ack_edge", ecnt, exp_e);
      check("busy_ack", busy, reconf);
      if (reconf) cur_m = nv[g];
      check("cur_n",  cur_n,  cur_m);
      check("div_n",  div_n,  cur_m);
      check("div_en", div_en, 1);
      ptr_m   = (g + 1) % NR;
      pend[g] = 1'b0;
      req[g]  = 1'b0;
      e0      = ecnt + 2;
      step();
      check("ack_pulse", ack,  0);
      check("busy_end",  busy, 0);
    end
  endtask

  initial begin
    int seen;
    req     = '0;
    req_n   = '0;
    div_out = 1'b0;
    reset_n = 1'b0;
    repeat (3) step();
    chk_rst();
    reset_n = 1'b1;
    step();
    check("boot_en", div_en, 1);
    repeat (10) step();
    check("idle_en",   div_en, 1);
    check("idle_divn", div_n,  2);
    check("idle_ack",  ack,    0);
    check("idle_busy", busy,   0);

    dmode = 0;
    batch(2'b01, 6, 0);
    batch(2'b10, 0, 5);
    batch(2'b10, 0, 0);
    batch(2'b11, 4, 8);
    batch(2'b11, 4, 8);
    dmode = 1;
    batch(2'b01, 10, 0);

    dmode = 2;
    repeat (40) begin
      logic [NR-1:0] m;
      logic [W-1:0]  a, b;
      m = NR'($urandom_range(1, 3));
      a = pick();
      b = pick();
      batch(m, a, b);
    end

    // Reset while the divider is settling.
    dmode = 0;
    req_n = {W'(0), (cur_m == 12) ? W'(14) : W'(12)};
    req   = 2'b01;
    repeat (6) step();
    check("busy_mid", busy, 1);
    reset_n = 1'b0;
    req     = '0;
    step();
    chk_rst();
    step();
    reset_n = 1'b1;
    ptr_m   = 0;
    cur_m   = 2;
    seen    = 0;
    repeat (20) begin
      step();
      if (ack != 0) seen++;
    end
    check("no_stale_ack", seen, 0);
    batch(2'b11, 6, 6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
